// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
// Handshake bundle for alu_issue_ctrl.
//   instr_* : instruction channel (valid/ready), offered by the issuer.
//   res_*   : result channel (valid/ready), offered by alu_issue_ctrl.
// Modports:
//   slave  : view used by alu_issue_ctrl (accepts instructions, emits results)
//   master : view used by the environment driving instructions and taking results
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_op;
  logic [AW-1:0]     instr_rd;
  logic [AW-1:0]     instr_rs1;
  logic [AW-1:0]     instr_rs2;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic [AW-1:0]     res_rd;
  logic              res_err;

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, res_ready,
    output instr_ready, res_valid, res_data, res_carry, res_rd, res_err
  );

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, res_ready,
    input  instr_ready, res_valid, res_data, res_carry, res_rd, res_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Sequential issue/retire wrapper around an external 8-bit combinational ALU.
// Instructions name registers of a small internal register file; operands are
// read at acceptance, driven to the ALU for one cycle, and the ALU result is
// written back and offered downstream.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   bus (slave)            instruction and result valid/ready channels
//   ld_en/ld_addr/ld_data  external register-file load, honoured in any state
//   rf_rd_addr/rf_rd_data  combinational debug read of the register file
//   alu_a/alu_b/alu_sel    registered operands/opcode to the ALU
//   alu_out/alu_carry      combinational ALU result
//   retired_cnt            number of completed result handshakes (mod 256)
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int DATA_W   = 8,
  parameter int RF_DEPTH = 4,
  parameter int AW       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   bus,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [AW-1:0]     rf_rd_addr,
  output logic [DATA_W-1:0] rf_rd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic [7:0]        retired_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [AW-1:0]     rd_q;
  logic [DATA_W-1:0] rf [RF_DEPTH];

  logic accept;
  logic retire;
  logic op_illegal;
  logic wb_en;

  // alu_sel holds the opcode of the instruction in flight while in EXEC.
  assign op_illegal = (alu_sel > 4'd9);
  assign accept     = (state == IDLE) && bus.instr_valid && bus.instr_ready;
  assign retire     = (state == RESP) && bus.res_valid && bus.res_ready;
  assign wb_en      = (state == EXEC) && !op_illegal;

  assign rf_rd_data = rf[rf_rd_addr];

  // Control FSM with registered outputs. instr_ready comes back one cycle
  // after reset release, and immediately on retire so the issue interval
  // stays at three cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.instr_ready <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sel       <= '0;
      rd_q          <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_carry <= 1'b0;
      bus.res_rd    <= '0;
      bus.res_err   <= 1'b0;
      retired_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Operands read here see the RF before any same-edge load.
            alu_a           <= rf[bus.instr_rs1];
            alu_b           <= rf[bus.instr_rs2];
            alu_sel         <= bus.instr_op;
            rd_q            <= bus.instr_rd;
            bus.instr_ready <= 1'b0;
            state           <= EXEC;
          end else begin
            bus.instr_ready <= 1'b1;
          end
        end
        EXEC: begin
          bus.res_valid <= 1'b1;
          bus.res_rd    <= rd_q;
          if (op_illegal) begin
            bus.res_err   <= 1'b1;
            bus.res_data  <= '0;
            bus.res_carry <= 1'b0;
          end else begin
            bus.res_err   <= 1'b0;
            bus.res_data  <= alu_out;
            bus.res_carry <= alu_carry;
          end
          state <= RESP;
        end
        RESP: begin
          if (retire) begin
            bus.res_valid   <= 1'b0;
            retired_cnt     <= retired_cnt + 8'd1;
            bus.instr_ready <= 1'b1;
            state           <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Register file. The writeback is the later assignment so it wins over an
  // external load to the same register on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (ld_en) begin
        rf[ld_addr] <= ld_data;
      end
      if (wb_en) begin
        rf[rd_q] <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Drives alu_issue_ctrl with directed and randomized instructions, models the
// external ALU combinationally, and checks every result against a register
// file and retire counter kept inside the bench.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DATA_W(8), .AW(2)) bus ();

  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [1:0] rf_rd_addr;
  logic [7:0] rf_rd_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic [7:0] retired_cnt;

  alu_issue_ctrl #(.DATA_W(8), .RF_DEPTH(4), .AW(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_carry   (alu_carry),
    .retired_cnt (retired_cnt)
  );

  // External ALU: {carry, result}. Carry is the carry-out of A+B for every op.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] sel);
    logic [8:0] s;
    logic [7:0] r;
    s = {1'b0, a} + {1'b0, b};
    case (sel)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = (b == 8'd0) ? 8'd0 : a / b;
      4'd4:    r = a << 1;
      4'd5:    r = a >> 1;
      4'd6:    r = {a[6:0], a[7]};
      4'd7:    r = {a[0], a[7:1]};
      4'd8:    r = (a > b) ? 8'd1 : 8'd0;
      4'd9:    r = (a == b) ? 8'd1 : 8'd0;
      default: r = a ^ b;
    endcase
    return {s[8], r};
  endfunction

  assign {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] ref_rf [4];
  logic [7:0] ref_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf();
    for (int i = 0; i < 4; i++) begin
      rf_rd_addr = 2'(i);
      #1;
      chk($sformatf("rf%0d", i), rf_rd_data, ref_rf[i]);
    end
  endtask

  task automatic do_load(input logic [1:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
    ref_rf[a] = d;
  endtask

  // ld_mode: 0 none, 1 load on the acceptance edge, 2 load on the EXEC edge.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input int stall, input int ld_mode,
                       input logic [1:0] ld_a, input logic [7:0] ld_d);
    logic [8:0] exp;
    logic [7:0] exp_a, exp_b, hold_data;
    logic       ill;
    int         k;
    k = 0;
    while (!bus.instr_ready && k < 20) begin
      tick();
      k++;
    end
    chk("ready_wait", bus.instr_ready, 1'b1);
    exp_a = ref_rf[rs1];
    exp_b = ref_rf[rs2];
    exp   = alu_fn(exp_a, exp_b, op);
    ill   = (op > 4'd9);

    bus.instr_valid = 1'b1;
    bus.instr_op    = op;
    bus.instr_rd    = rd;
    bus.instr_rs1   = rs1;
    bus.instr_rs2   = rs2;
    if (ld_mode == 1) begin
      ld_en = 1'b1; ld_addr = ld_a; ld_data = ld_d;
    end
    tick();
    bus.instr_valid = 1'b0;
    ld_en = 1'b0;
    if (ld_mode == 1) ref_rf[ld_a] = ld_d;
    chk("exec_ready", bus.instr_ready, 1'b0);
    chk("exec_valid", bus.res_valid, 1'b0);
    chk("alu_a", alu_a, exp_a);
    chk("alu_b", alu_b, exp_b);
    chk("alu_sel", alu_sel, op);

    if (ld_mode == 2) begin
      ld_en = 1'b1; ld_addr = ld_a; ld_data = ld_d;
    end
    tick();
    ld_en = 1'b0;
    if (ld_mode == 2) ref_rf[ld_a] = ld_d;
    if (!ill) ref_rf[rd] = exp[7:0];
    hold_data = ill ? 8'h00 : exp[7:0];
    chk("res_valid", bus.res_valid, 1'b1);
    chk("res_data", bus.res_data, hold_data);
    chk("res_carry", bus.res_carry, ill ? 1'b0 : exp[8]);
    chk("res_rd", bus.res_rd, rd);
    chk("res_err", bus.res_err, ill);
    chk("resp_ready", bus.instr_ready, 1'b0);
    chk("resp_cnt", retired_cnt, ref_cnt);
    chk("alu_a_hold", alu_a, exp_a);

    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_valid", bus.res_valid, 1'b1);
      chk("stall_data", bus.res_data, hold_data);
      chk("stall_ready", bus.instr_ready, 1'b0);
      chk("stall_cnt", retired_cnt, ref_cnt);
    end

    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    ref_cnt = ref_cnt + 8'd1;
    chk("done_valid", bus.res_valid, 1'b0);
    chk("done_cnt", retired_cnt, ref_cnt);
    chk("done_ready", bus.instr_ready, 1'b1);
    check_rf();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_op    = '0;
    bus.instr_rd    = '0;
    bus.instr_rs1   = '0;
    bus.instr_rs2   = '0;
    bus.res_ready   = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rf_rd_addr = '0;
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    ref_cnt = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst_ready", bus.instr_ready, 1'b0);
    chk("rst_valid", bus.res_valid, 1'b0);
    chk("rst_data", bus.res_data, 8'h00);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_sel", alu_sel, 4'h0);
    chk("rst_cnt", retired_cnt, 8'h00);
    check_rf();
    rst_n = 1'b1;
    tick();

    // ADD with carry
    do_load(2'd0, 8'hF0);
    do_load(2'd1, 8'h20);
    issue(4'd0, 2'd2, 2'd0, 2'd1, 0, 0, 2'd0, 8'h00);
    chk("add_r2", ref_rf[2] == 8'h10, 1'b1);

    // SUB then compare
    do_load(2'd0, 8'h05);
    do_load(2'd1, 8'h07);
    issue(4'd1, 2'd3, 2'd0, 2'd1, 0, 0, 2'd0, 8'h00);
    issue(4'd8, 2'd3, 2'd1, 2'd0, 0, 0, 2'd0, 8'h00);

    // Illegal opcode, no writeback to R0
    issue(4'd12, 2'd0, 2'd0, 2'd1, 0, 0, 2'd0, 8'h00);

    // Downstream back-pressure
    issue(4'd0, 2'd1, 2'd0, 2'd1, 5, 0, 2'd0, 8'h00);

    // Writeback beats a same-edge load to the same register
    do_load(2'd0, 8'hF0);
    do_load(2'd1, 8'h20);
    issue(4'd0, 2'd2, 2'd0, 2'd1, 0, 2, 2'd2, 8'hAA);
    // Load to a source after acceptance does not disturb the operands
    issue(4'd0, 2'd3, 2'd1, 2'd1, 0, 2, 2'd1, 8'h5A);
    // Load on the acceptance edge: operand sees the pre-edge value
    issue(4'd1, 2'd0, 2'd1, 2'd2, 1, 1, 2'd1, 8'h33);

    // Randomized instructions
    for (int n = 0; n < 40; n++) begin
      issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 2),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    // Reset asserted during EXEC
    while (!bus.instr_ready) tick();
    bus.instr_valid = 1'b1;
    bus.instr_op = 4'd0; bus.instr_rd = 2'd1; bus.instr_rs1 = 2'd2; bus.instr_rs2 = 2'd3;
    tick();
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", bus.instr_ready, 1'b0);
    chk("mrst_valid", bus.res_valid, 1'b0);
    chk("mrst_alu_a", alu_a, 8'h00);
    chk("mrst_alu_b", alu_b, 8'h00);
    chk("mrst_cnt", retired_cnt, 8'h00);
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    ref_cnt = 8'h00;
    check_rf();
    tick();
    tick();
    chk("mrst_no_res", bus.res_valid, 1'b0);
    rst_n = 1'b1;
    issue(4'd0, 2'd1, 2'd0, 2'd0, 0, 0, 2'd0, 8'h00);

    // Counter wrap: 1 retired above, 255 more brings it back to 0
    for (int n = 0; n < 255; n++) begin
      issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 0, $urandom_range(0, 2),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    chk("cnt_wrap", retired_cnt, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
